// File: rtl/eight_req_priority_arbiter_if.sv
// rtl/eight_req_priority_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface eight_req_priority_arbiter_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       preempt;

    modport master (
        output en,
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  en,
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );
endinterface

// File: rtl/eight_req_priority_arbiter.sv
// rtl/eight_req_priority_arbiter.sv - 8-way registered grant arbiter with hold-limit preemption
// Optional macro ARB_RR_EN selects rotating priority instead of fixed 7-highest priority.
module eight_req_priority_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    eight_req_priority_arbiter_if.slave   arb
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_id_q, gnt_id_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             preempt_q, preempt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       mask_q, mask_d;

    logic [7:0]       eff;
    logic [2:0]       prio_top;
    logic [2:0]       win;
    logic [2:0]       pick_idx;
    logic             pick_found;
    logic             holder_req;
    logic             hold_limit;

`ifdef ARB_RR_EN
    logic [2:0]       top_q, top_d;
    assign prio_top = top_q;
`else
    assign prio_top = 3'd7;
`endif

    // The one-shot mask only steers the choice; if it would exclude everyone, fall back to raw req.
    always_comb begin
        eff = arb.req & ~mask_q;
        if (eff == 8'h00) begin
            eff = arb.req;
        end
    end

    // Scan downward from the top-priority index, wrapping modulo 8.
    always_comb begin
        win        = prio_top;
        pick_idx   = prio_top;
        pick_found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pick_idx = prio_top - 3'(i);
            if (!pick_found && eff[pick_idx]) begin
                win        = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    assign holder_req = arb.req[gnt_id_q];
    assign hold_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        preempt_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        mask_d      = mask_q;
`ifdef ARB_RR_EN
        top_d       = top_q;
`endif
        case (state_q)
            IDLE: begin
                if (arb.en && (arb.req != 8'h00)) begin
                    state_d     = GRANT;
                    gnt_d       = 8'h01 << win;
                    gnt_id_d    = win;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    mask_d      = 8'h00;
`ifdef ARB_RR_EN
                    top_d       = win - 3'd1;
`endif
                end
            end
            GRANT: begin
                // Release takes precedence over the hold limit on the same edge.
                if (!holder_req) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                end else if (hold_limit) begin
                    state_d     = IDLE;
                    gnt_d       = 8'h00;
                    gnt_id_d    = 3'd0;
                    gnt_valid_d = 1'b0;
                    hold_cnt_d  = '0;
                    preempt_d   = 1'b1;
                    mask_d      = gnt_q;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d  = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            preempt_q   <= 1'b0;
            hold_cnt_q  <= '0;
            mask_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            preempt_q   <= preempt_d;
            hold_cnt_q  <= hold_cnt_d;
            mask_q      <= mask_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= 3'd7;
        end else begin
            top_q <= top_d;
        end
    end
`endif

    assign arb.gnt       = gnt_q;
    assign arb.gnt_id    = gnt_id_q;
    assign arb.gnt_valid = gnt_valid_q;
    assign arb.preempt   = preempt_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_valid_match: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid_q == (|gnt_q));
    a_preempt_idle: assert property (@(posedge clk) disable iff (!rst_n) preempt_q |-> !gnt_valid_q);

endmodule

// File: tb/tb_eight_req_priority_arbiter.sv
// tb/tb_eight_req_priority_arbiter.sv - directed bench with cycle-level reference model
module tb_eight_req_priority_arbiter;

    localparam int MH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    eight_req_priority_arbiter_if arb_if();

    eight_req_priority_arbiter #(.MAX_HOLD(MH), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .arb   (arb_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference: holder index (-1 = none), cycles served, mask and rotating top kept as plain ints.
    int         m_holder  = -1;
    int         m_cnt     = 0;
    int         m_top     = 7;
    int         m_w;
    logic [7:0] m_mask    = 8'h00;
    logic [7:0] m_cand;
    logic       m_preempt = 1'b0;
    logic [7:0] exp_gnt;
    int         exp_seq [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_holder  = -1;
            m_cnt     = 0;
            m_mask    = 8'h00;
            m_top     = 7;
            m_preempt = 1'b0;
        end else begin
            m_preempt = 1'b0;
            if (m_holder < 0) begin
                if (arb_if.en && arb_if.req != 8'h00) begin
                    m_cand = arb_if.req & ~m_mask;
                    if (m_cand == 8'h00) m_cand = arb_if.req;
                    m_w = -1;
                    for (int p = 0; p < 8; p++) begin
                        if (m_w < 0 && m_cand[(m_top - p + 8) % 8]) m_w = (m_top - p + 8) % 8;
                    end
                    m_holder = m_w;
                    m_cnt    = 0;
                    m_mask   = 8'h00;
`ifdef ARB_RR_EN
                    m_top    = (m_w + 7) % 8;
`endif
                end
            end else if (!arb_if.req[m_holder]) begin
                m_holder = -1;
            end else if (MH != 0 && m_cnt == MH - 1) begin
                m_mask    = 8'(1 << m_holder);
                m_holder  = -1;
                m_preempt = 1'b1;
            end else begin
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        exp_gnt = (m_holder >= 0) ? 8'(1 << m_holder) : 8'h00;
        chk("model_gnt", arb_if.gnt, exp_gnt);
        chk("model_gnt_valid", arb_if.gnt_valid, m_holder >= 0);
        chk("model_preempt", arb_if.preempt, m_preempt);
        if (m_holder >= 0) chk("model_gnt_id", arb_if.gnt_id, m_holder);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        arb_if.req = 8'h00;
        arb_if.en  = 1'b0;
        tick(2);
        chk("reset_gnt", arb_if.gnt, 8'h00);
        chk("reset_gnt_id", arb_if.gnt_id, 3'd0);
        chk("reset_gnt_valid", arb_if.gnt_valid, 1'b0);
        chk("reset_preempt", arb_if.preempt, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        arb_if.en  = 1'b0;
        arb_if.req = 8'h00;
        #1 rst_n = 1'b0;

        // Basic grant, release, next grant
        do_reset();
        arb_if.en  = 1'b1;
        arb_if.req = 8'b0010_0100;
        tick(1);
        chk("t1_gnt", arb_if.gnt, 8'b0010_0000);
        chk("t1_gnt_id", arb_if.gnt_id, 3'd5);
        chk("t1_valid", arb_if.gnt_valid, 1'b1);
        arb_if.req = 8'b0000_0100;
        tick(1);
        chk("t1_release", arb_if.gnt, 8'h00);
        tick(1);
        chk("t1_gnt2", arb_if.gnt, 8'b0000_0100);
        chk("t1_gnt2_id", arb_if.gnt_id, 3'd2);
        arb_if.req = 8'h00;
        tick(2);

        // Hold limit preemption and one-shot mask
        do_reset();
        arb_if.en  = 1'b1;
        arb_if.req = 8'b1000_0001;
        for (int c = 0; c < MH; c++) begin
            tick(1);
            chk("t2_hold_gnt", arb_if.gnt, 8'h80);
            chk("t2_hold_preempt", arb_if.preempt, 1'b0);
        end
        tick(1);
        chk("t2_pre_gnt", arb_if.gnt, 8'h00);
        chk("t2_pre_pulse", arb_if.preempt, 1'b1);
        tick(1);
        chk("t2_mask_id", arb_if.gnt_id, 3'd0);
        chk("t2_mask_gnt", arb_if.gnt, 8'h01);
        chk("t2_pulse_end", arb_if.preempt, 1'b0);
        arb_if.req = 8'h80;
        tick(1);
        chk("t2_rel0", arb_if.gnt, 8'h00);
        tick(1);
        chk("t2_again7", arb_if.gnt, 8'h80);
        arb_if.req = 8'h00;
        tick(2);

        // Enable gating
        do_reset();
        arb_if.req = 8'hFF;
        for (int c = 0; c < 10; c++) begin
            tick(1);
            chk("t3_en_off", arb_if.gnt, 8'h00);
        end
        arb_if.en = 1'b1;
        tick(1);
        chk("t3_en_on_id", arb_if.gnt_id, 3'd7);
        chk("t3_en_on_valid", arb_if.gnt_valid, 1'b1);
        arb_if.en = 1'b0;
        tick(2);
        chk("t3_en_mid", arb_if.gnt, 8'h80);
        arb_if.req = 8'h00;
        tick(2);

        // Release coincident with hold limit
        do_reset();
        arb_if.en  = 1'b1;
        arb_if.req = 8'b1000_0001;
        tick(MH);
        chk("t4_held", arb_if.gnt, 8'h80);
        arb_if.req = 8'b0000_0001;
        tick(1);
        chk("t4_rel_gnt", arb_if.gnt, 8'h00);
        chk("t4_rel_preempt", arb_if.preempt, 1'b0);
        arb_if.req = 8'b1000_0001;
        tick(1);
`ifdef ARB_RR_EN
        chk("t4_nomask", arb_if.gnt, 8'h01);
`else
        chk("t4_nomask", arb_if.gnt, 8'h80);
`endif
        arb_if.req = 8'h00;
        tick(2);

        // Asynchronous reset mid-grant
        do_reset();
        arb_if.en  = 1'b1;
        arb_if.req = 8'h08;
        tick(2);
        chk("t5_gnt_id", arb_if.gnt_id, 3'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_gnt", arb_if.gnt, 8'h00);
        chk("t5_async_valid", arb_if.gnt_valid, 1'b0);
        chk("t5_async_preempt", arb_if.preempt, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("t5_regrant_id", arb_if.gnt_id, 3'd3);
        chk("t5_regrant_valid", arb_if.gnt_valid, 1'b1);
        arb_if.req = 8'h00;
        tick(2);

        // Grant order with every requester active
`ifdef ARB_RR_EN
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
`else
        exp_seq = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`endif
        do_reset();
        arb_if.en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            arb_if.req = 8'hFF;
            tick(1);
            chk("t6_seq_id", arb_if.gnt_id, exp_seq[k]);
            chk("t6_seq_valid", arb_if.gnt_valid, 1'b1);
            arb_if.req = ~8'(1 << exp_seq[k]);
            tick(1);
            chk("t6_seq_gap", arb_if.gnt, 8'h00);
        end
        arb_if.req = 8'h00;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/eight_req_priority_arbiter.md
Name: eight_req_priority_arbiter

Overview:
Sequential arbiter that shares one resource among 8 requesters. Winner selection uses the 8:3 priority rule: highest set index wins, so 7 has highest priority. The grant is registered and held until the holder releases it or a hold limit preempts it. A one-shot mask after preemption prevents a high-index requester from starving the others. The block sits in front of any shared datapath that currently takes an 8-bit request vector into the 8x3 priority encoder.

Parameters:
MAX_HOLD, 16, maximum consecutive cycles one grant may be held; 0 = unlimited, preemption disabled
CNT_W, 5, width of the hold counter; must hold MAX_HOLD-1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
en  input  1  arbitration enable; gates new grants only
req  input  8  request vector; req[i] held high while requester i wants or uses the resource
gnt  output  8  one-hot grant, registered
gnt_id  output  3  binary index of the holder, valid when gnt_valid=1
gnt_valid  output  1  high while any grant is held (equals |gnt)
preempt  output  1  one-cycle pulse when a grant is forcibly removed by the hold limit

Behaviour:
- One clock, clk. Reset rst_n is asynchronous and active-low. All state is clocked on the rising edge of clk.
- Reset values: gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, hold_cnt=0, mask=0, top=7.
- Reset asserted mid-grant: all outputs clear immediately, with no preempt pulse.
- States:
  - IDLE: no grant.
  - GRANT: gnt[id]=1.
- IDLE -> GRANT at an edge where en=1 and req!=0.
  - eff = req & ~mask. If eff==0, then eff = req.
  - Winner = highest set index of eff, using the priority order below.
  - At the same edge: gnt <= onehot(winner), gnt_id <= winner, gnt_valid <= 1, hold_cnt <= 0, mask <= 0.
- Grant latency: gnt rises one cycle after req is first seen high, i.e. at the first edge that samples req.
- GRANT, holder's req[gnt_id]=0 at an edge: go to IDLE and clear gnt/gnt_valid. preempt stays 0.
- GRANT, req[gnt_id]=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1: go to IDLE and clear gnt.
  - preempt <= 1 for exactly one cycle.
  - mask <= onehot(holder).
  - The holder therefore sees gnt high for exactly MAX_HOLD cycles.
- Otherwise in GRANT: hold_cnt increments and saturates at its maximum when MAX_HOLD=0.
- Requests from non-holders during GRANT are ignored; they are not queued.
- Minimum of 1 dead cycle (IDLE) between any two grants, including when the same requester re-asserts.
- en=0 blocks IDLE->GRANT only. An existing grant continues until release or preempt. mask persists while en=0.
- Simultaneous release and hold-limit at the same edge: release wins. preempt=0, mask is not set.
- gnt is always one-hot or zero, and gnt_id is stable for the whole grant.

Optional Feature:
Macro ARB_RR_EN.
- Defined: rotating priority.
  - Register top[2:0] (reset 7) is the highest-priority index; priority then descends with wrap: top, top-1, ..., top+1.
  - On each issued grant to k: top <= (k-1) mod 8.
  - mask logic still applies.
- Undefined: fixed priority, 7 highest down to 0 lowest; the top register is not present.

Test Plan:
- Reset then req=8'b0010_0100, en=1 -> after 1 edge gnt=8'b0010_0000, gnt_id=5, gnt_valid=1; req[5] drops -> next edge gnt=0; following edge gnt=8'b0000_0100, gnt_id=2.
- MAX_HOLD=4, req=8'b1000_0001 held -> gnt_id=7 for exactly 4 cycles, preempt pulses 1 cycle with gnt=0, next edge gnt_id=0 (mask); after 0 releases, 7 wins again.
- en=0 with req=8'hFF -> gnt stays 0 for 10 cycles; en=1 -> gnt_id=7 one edge later; en=0 mid-grant does not drop the grant.
- Holder drops req on the same edge hold_cnt==MAX_HOLD-1 -> gnt clears, preempt=0, mask=0 (next arbitration with req=8'b1000_0001 picks 7).
- rst_n low mid-grant (gnt_id=3) -> gnt=0, gnt_valid=0, preempt=0 immediately without a clock edge; after release, req=8'h08 -> gnt_id=3 one edge later.
- ARB_RR_EN defined, req=8'hFF held, each holder releases after 1 cycle -> grant sequence 7,6,5,4,3,2,1,0,7; undefined -> 7 every time (MAX_HOLD=0).
